crc32_chunk_sched: RTL and testbench
====================================

// Module: crc32_chunk_sched
// PURPOSE
//  Shares one byte-serial CRC-32 engine (poly 0x04C11DB7, init/xorout 0xFFFFFFFF, reflected) between
//  NUM_REQ PNG chunk producers (e.g. IHDR/IEND generator, IDAT packer).
//  Arbitrates per chunk (round-robin) and accepts 32-bit words via valid/ready.
//  Steps the engine one byte per cycle, honours a partial last word, and returns the final CRC tagged with the requester id.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  ID_WD    1   width of crc_id_o, >= clog2(NUM_REQ)
// PORTS
//  clk         in   1            clock
//  rstn        in   1            async active-low reset
//  req_val_i   in   NUM_REQ      word valid, per requester
//  req_dat_i   in   NUM_REQ*32   word data, req r in [32r+31:32r], byte order [31:24] first
//  req_lst_i   in   NUM_REQ      word is last of chunk
//  req_bcnt_i  in   NUM_REQ*2    valid bytes in last word (0 means 4, 1..3 means upper 1..3 bytes); ignored when lst=0
//  req_rdy_o   out  NUM_REQ      word accepted when val&rdy
//  crc_val_o   out  1            final CRC valid
//  crc_dat_o   out  32           final CRC, PNG byte order ([31:24] written first)
//  crc_id_o    out  ID_WD        requester owning crc_dat_o
//  crc_rdy_i   in   1            CRC consumer ready
//  busy_o      out  1            chunk in progress (state != IDLE)
// BEHAVIOUR
//  - Clock and reset: one clock. rstn is asynchronous, active-low.
//  - Reset values: state=IDLE, rr pointer=0, crc reg=0xFFFFFFFF, req_rdy_o=0, crc_val_o=0, crc_dat_o=0, crc_id_o=0, busy_o=0.
//  - States:
//    - IDLE -> LOAD when any req_val_i. The grant goes to the first requester with val=1 searching upward from the rr pointer (wrap).
//      The crc reg is set to 0xFFFFFFFF on this transition.
//    - LOAD: the granted requester's req_rdy_o=1; all other requesters' rdy=0.
//      On val&rdy: capture the word and nbyt (4, or bcnt when lst, 0 mapped to 4), then go to SHIFT.
//      While val=0: hold with the crc untouched (stall allowed mid-chunk).
//    - SHIFT: each cycle steps the crc with one byte via crc32_nrm_8bits. Bytes go in order [31:24],[23:16],[15:8],[7:0],
//      each bit-reversed before the step. Exactly nbyt steps are taken.
//      The granted req_rdy_o is also 1 during the final byte step of a non-last word. A word accepted then starts stepping
//      the next cycle, so sustained rate is 1 word per 4 cycles with no bubble.
//      After the last step of a non-last word with no new word accepted -> LOAD.
//      After the last step of a lst word -> DONE.
//    - DONE: crc_val_o=1, crc_dat_o = bitrev32(crc) ^ 0xFFFFFFFF, crc_id_o = grant.
//      These outputs are registered and asserted on the same edge as the final byte step.
//      They are held stable until crc_rdy_i=1. At that edge: crc_val_o=0, rr pointer = grant+1 (mod NUM_REQ), -> IDLE.
//  - Latency: a word with lst=1, bcnt=n accepted at edge E. Byte steps occur at E+1..E+n. crc_val_o is high from edge E+n.
//  - The grant is locked from LOAD entry until the DONE handshake; the rdy of a non-granted requester is never 1.
//  - A new grant is made no earlier than the cycle after the DONE handshake (IDLE lasts at least one cycle).
//  - req_val_i of a non-granted requester may toggle freely. The granted requester must not drop val while rdy=1.
//  - lst=1 with bcnt=0 processes 4 bytes. A chunk of a single last word is legal.
//  - Async reset mid-chunk aborts: all state returns to reset values; no partial CRC is emitted.
//  - The 8-bit step is the only arithmetic. All crc widths are 32, byte counter 3 bits, no overflow paths.
// STRUCTURE
//  - crc32_pkg: CRC32_POLY=32'h04C11DB7, CRC32_INIT=32'hFFFF_FFFF, CRC32_XOROUT=32'hFFFF_FFFF, DATA_WD=32,
//    state encoding (IDLE/LOAD/SHIFT/DONE), bitrev8/bitrev32 functions.
//  - Sub-module: one instance of existing crc32_nrm_8bits (combinational byte step); FSM, arbiter and byte counter stay local.
// TESTING
//  1) Req0 sends one word 0x49454E44 ("IEND"), lst=1, bcnt=0 -> crc_val_o at E+4, crc_dat_o=0xAE426082, crc_id_o=0.
//  2) Req1 sends 0x31323334, 0x35363738, then 0x39xxxxxx with lst=1, bcnt=1 ("123456789") -> crc_dat_o=0xCBF43926, id=1;
//     words accepted every 4 cycles with no bubble.
//  3) Both requesters hold val at reset release -> req0 granted first, req1 granted after DONE handshake, CRCs correct for each.
//  4) Req0 drops val for 5 cycles mid-chunk and crc_rdy_i is held 0 for 3 cycles in DONE -> same CRC as unstalled run;
//     crc outputs stable while held.
//  5) Assert rstn=0 during SHIFT of a multi-word chunk -> all outputs at reset values immediately.
//     The next chunk after release gives the correct CRC.
//  6) Req0 sends 0x49484452 ("IHDR") then 0x00000001, 0x00000001, 0x08060000, 0x00xxxxxx (lst=1, bcnt=1) -> crc_dat_o=0x1F15C489.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared constants, FSM encoding and bit-reversal helpers for the
// PNG chunk CRC-32 scheduler.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
   localparam int          DATA_WD      = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [7:0] bitrev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = d[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc32_nrm_8bits.sv
// Combinational MSB-first (non-reflected) CRC-32 update by one byte.
module crc32_nrm_8bits
   import crc32_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_dat,
   output logic [31:0] o_crc
);

   logic [31:0] w_crc;

   // NOTE: blocking assignments here so each bit iteration feeds the next within one combinational pass.
   always_comb begin
      w_crc = i_crc;
      for (int i = 7; i >= 0; i--) begin
         if (w_crc[31] ^ i_dat[i]) w_crc = {w_crc[30:0], 1'b0} ^ CRC32_POLY;
         else                      w_crc = {w_crc[30:0], 1'b0};
      end
      o_crc = w_crc;
   end

endmodule

// File: rtl/crc32_chunk_sched.sv
// Round-robin scheduler sharing one byte-serial CRC-32 engine between
// NUM_REQ chunk producers; returns the final CRC tagged with the owner id.
module crc32_chunk_sched
   import crc32_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_WD   = 1
)(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NUM_REQ-1:0]         req_val_i,
   input  logic [NUM_REQ*DATA_WD-1:0] req_dat_i,
   input  logic [NUM_REQ-1:0]         req_lst_i,
   input  logic [NUM_REQ*2-1:0]       req_bcnt_i,
   output logic [NUM_REQ-1:0]         req_rdy_o,
   output logic                       crc_val_o,
   output logic [31:0]                crc_dat_o,
   output logic [ID_WD-1:0]           crc_id_o,
   input  logic                       crc_rdy_i,
   output logic                       busy_o
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [ID_WD-1:0]   r_grant;
   logic [ID_WD-1:0]   r_rr_ptr;
   logic [31:0]        r_crc;
   logic [31:0]        r_word;
   logic [2:0]         r_nbyt;
   logic [2:0]         r_bidx;
   logic               r_lst;

   logic [ID_WD-1:0]   w_grant_nxt;
   logic [NUM_REQ-1:0] w_rdy;
   logic [31:0]        w_crc_step;
   logic [DATA_WD-1:0] w_sel_dat;
   logic               w_sel_lst;
   logic [1:0]         w_sel_bcnt;
   logic               w_last_step;
   logic               w_acc;

   crc32_nrm_8bits u_step (
      .i_crc (r_crc),
      .i_dat (bitrev8(r_word[31:24])),
      .o_crc (w_crc_step)
   );

   assign w_sel_dat   = req_dat_i[int'(r_grant)*DATA_WD +: DATA_WD];
   assign w_sel_lst   = req_lst_i[r_grant];
   assign w_sel_bcnt  = req_bcnt_i[int'(r_grant)*2 +: 2];
   assign w_last_step = (r_state == ST_SHIFT) && (r_bidx == r_nbyt - 3'd1);
   assign w_acc       = req_val_i[r_grant] & w_rdy[r_grant];

   // First requesting index at or above the rr pointer, wrapping.
   always_comb begin
      w_grant_nxt = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_val_i[(int'(r_rr_ptr) + i) % NUM_REQ])
            w_grant_nxt = ID_WD'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every path starts from the default assignment, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (|req_val_i) w_state_nxt = ST_LOAD;
         ST_LOAD:  if (w_acc)      w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last_step) begin
                      if (r_lst)       w_state_nxt = ST_DONE;
                      else if (!w_acc) w_state_nxt = ST_LOAD;
                   end
         ST_DONE:  if (crc_rdy_i)  w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rdy = '0;
      if (r_state == ST_LOAD || (w_last_step && !r_lst)) w_rdy[r_grant] = 1'b1;
   end

   assign req_rdy_o = w_rdy;
   assign busy_o    = (r_state != ST_IDLE);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_crc     <= CRC32_INIT;
         r_word    <= '0;
         r_nbyt    <= '0;
         r_bidx    <= '0;
         r_lst     <= 1'b0;
         crc_val_o <= 1'b0;
         crc_dat_o <= '0;
         crc_id_o  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (|req_val_i) begin
               r_grant <= w_grant_nxt;
               r_crc   <= CRC32_INIT;
            end
            ST_SHIFT: begin
               r_crc  <= w_crc_step;
               r_word <= {r_word[23:0], 8'h00};
               r_bidx <= r_bidx + 3'd1;
               if (w_last_step && r_lst) begin
                  crc_val_o <= 1'b1;
                  crc_dat_o <= bitrev32(w_crc_step) ^ CRC32_XOROUT;
                  crc_id_o  <= r_grant;
               end
            end
            ST_DONE: if (crc_rdy_i) begin
               crc_val_o <= 1'b0;
               r_rr_ptr  <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;
            end
            default: ;
         endcase
         // A word accepted on the final step overrides the shift so stepping continues without a bubble.
         if (w_acc) begin
            r_word <= w_sel_dat;
            r_lst  <= w_sel_lst;
            r_nbyt <= (w_sel_lst && w_sel_bcnt != 2'd0) ? {1'b0, w_sel_bcnt} : 3'd4;
            r_bidx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_crc32_chunk_sched.sv
// Self-checking bench: known PNG chunk vectors, arbitration/stall/reset
// sequences and randomized chunks against a reflected CRC-32 model.
module tb_crc32_chunk_sched;

   localparam int NUM_REQ = 2;
   localparam int ID_WD   = 1;

   typedef logic [4:0][31:0] words_t;

   typedef struct {
      string       name;
      int          id;
      int          nw;
      words_t      w;
      logic [1:0]  bcnt;
      logic [31:0] exp;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [NUM_REQ-1:0]     req_val_i;
   logic [NUM_REQ*32-1:0]  req_dat_i;
   logic [NUM_REQ-1:0]     req_lst_i;
   logic [NUM_REQ*2-1:0]   req_bcnt_i;
   logic [NUM_REQ-1:0]     req_rdy_o;
   logic                   crc_val_o;
   logic [31:0]            crc_dat_o;
   logic [ID_WD-1:0]       crc_id_o;
   logic                   crc_rdy_i;
   logic                   busy_o;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int last_acc [NUM_REQ];

   crc32_chunk_sched #(.NUM_REQ(NUM_REQ), .ID_WD(ID_WD)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_val_i  (req_val_i),
      .req_dat_i  (req_dat_i),
      .req_lst_i  (req_lst_i),
      .req_bcnt_i (req_bcnt_i),
      .req_rdy_o  (req_rdy_o),
      .crc_val_o  (crc_val_o),
      .crc_dat_o  (crc_dat_o),
      .crc_id_o   (crc_id_o),
      .crc_rdy_i  (crc_rdy_i),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // At most one requester may ever see rdy.
   always @(negedge clk) if (rstn === 1'b1) check("rdy_onehot", 32'($countones(req_rdy_o) <= 1), 1);

   function automatic words_t mk5(input logic [31:0] a, b, c, d, e);
      words_t w;
      w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
      return w;
   endfunction

   function automatic int nbytes(input logic [1:0] bcnt);
      return (bcnt == 2'd0) ? 4 : int'(bcnt);
   endfunction

   // Reflected CRC-32 (LSB-first, poly 0xEDB88320) over the chunk's byte stream.
   function automatic logic [31:0] ref_crc(input int nw, input words_t w, input logic [1:0] bcnt);
      logic [31:0] c;
      logic [7:0]  by;
      int          nb;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < nw; k++) begin
         nb = (k == nw - 1) ? nbytes(bcnt) : 4;
         for (int b = 0; b < nb; b++) begin
            by = w[k][31-8*b -: 8];
            c  = c ^ {24'h0, by};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic send_chunk(input int id, input int nw, input words_t w, input logic [1:0] bcnt,
                             input int stall_after, input int stall_len, input bit chk_rate);
      int guard;
      int prev;
      prev = 0;
      for (int k = 0; k < nw; k++) begin
         req_dat_i[32*id +: 32] = w[k];
         req_lst_i[id]          = (k == nw - 1);
         req_bcnt_i[2*id +: 2]  = (k == nw - 1) ? bcnt : 2'($urandom_range(0, 3));
         req_val_i[id]          = 1'b1;
         guard = 0;
         do begin @(negedge clk); guard++; end while (!req_rdy_o[id] && guard < 400);
         if (!req_rdy_o[id]) begin
            check($sformatf("rdy_timeout_r%0d_w%0d", id, k), 0, 1);
            req_val_i[id] = 1'b0;
            return;
         end
         @(posedge clk); #1;
         last_acc[id] = cyc;
         if (chk_rate && k > 0) check($sformatf("word_spacing_r%0d_w%0d", id, k), cyc - prev, 4);
         prev = cyc;
         if (k == nw - 1 || k == stall_after) begin
            req_val_i[id]          = 1'b0;
            req_dat_i[32*id +: 32] = $urandom;
         end
         if (k == stall_after) begin
            repeat (stall_len) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic get_crc(input string name, input int exp_id, input logic [31:0] exp_crc,
                          input int exp_lat, input int hold);
      int guard;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!crc_val_o && guard < 400);
      if (!crc_val_o) begin
         check({name, "_val_timeout"}, 0, 1);
         return;
      end
      check({name, "_crc"}, crc_dat_o, exp_crc);
      check({name, "_id"}, 32'(crc_id_o), exp_id);
      check({name, "_latency"}, cyc - last_acc[exp_id], exp_lat);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, "_hold_val"}, 32'(crc_val_o), 1);
         check({name, "_hold_crc"}, crc_dat_o, exp_crc);
         check({name, "_hold_id"}, 32'(crc_id_o), exp_id);
      end
      crc_rdy_i = 1'b1;
      @(posedge clk); #1;
      crc_rdy_i = 1'b0;
      check({name, "_val_drop"}, 32'(crc_val_o), 0);
      check({name, "_idle_after"}, 32'(busy_o), 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv [3];
      int          guard;
      int          id, nw, stall_after, stall_len, hold;
      words_t      w;
      logic [1:0]  bcnt;

      tv[0] = '{"iend", 0, 1, mk5(32'h4945_4E44, 0, 0, 0, 0), 2'd0, 32'hAE42_6082};
      tv[1] = '{"ihdr", 0, 5, mk5(32'h4948_4452, 32'h0000_0001, 32'h0000_0001,
                                  32'h0806_0000, 32'h00A5_A5A5), 2'd1, 32'h1F15_C489};
      tv[2] = '{"digits", 1, 3, mk5(32'h3132_3334, 32'h3536_3738, 32'h39AA_BBCC, 0, 0),
                2'd1, 32'hCBF4_3926};

      rstn       = 1'b0;
      req_val_i  = '0;
      req_dat_i  = '0;
      req_lst_i  = '0;
      req_bcnt_i = '0;
      crc_rdy_i  = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_rdy",  32'(req_rdy_o), 0);
      check("rst_val",  32'(crc_val_o), 0);
      check("rst_crc",  crc_dat_o, 0);
      check("rst_id",   32'(crc_id_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      rstn = 1'b1;

      // Known vectors: single last word, 5-word IHDR, 3-word back-to-back.
      for (int i = 0; i < 3; i++) begin
         send_chunk(tv[i].id, tv[i].nw, tv[i].w, tv[i].bcnt, -1, 0, 1'b1);
         get_crc(tv[i].name, tv[i].id, tv[i].exp, nbytes(tv[i].bcnt), 0);
      end

      // Reset in the middle of a multi-word chunk.
      req_dat_i[31:0]  = 32'h3132_3334;
      req_lst_i[0]     = 1'b0;
      req_bcnt_i[1:0]  = 2'd0;
      req_val_i[0]     = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!req_rdy_o[0] && guard < 50);
      check("t5_accept", 32'(req_rdy_o[0]), 1);
      @(posedge clk); #1;
      req_val_i[0] = 1'b0;
      @(posedge clk); #1;
      check("t5_busy_pre", 32'(busy_o), 1);
      rstn = 1'b0;
      #1;
      check("t5_rst_rdy",  32'(req_rdy_o), 0);
      check("t5_rst_val",  32'(crc_val_o), 0);
      check("t5_rst_crc",  crc_dat_o, 0);
      check("t5_rst_id",   32'(crc_id_o), 0);
      check("t5_rst_busy", 32'(busy_o), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      send_chunk(1, 1, tv[0].w, 2'd0, -1, 0, 1'b0);
      get_crc("t5_after", 1, 32'hAE42_6082, 4, 0);

      // Both requesters waiting at reset release: req0 first, req1 after the handshake.
      @(posedge clk); #1;
      rstn = 1'b0;
      fork
         send_chunk(0, 1, tv[0].w, 2'd0, -1, 0, 1'b0);
         send_chunk(1, 3, tv[2].w, 2'd1, -1, 0, 1'b1);
         begin
            repeat (2) @(negedge clk);
            check("t3_rst_busy", 32'(busy_o), 0);
            rstn = 1'b1;
            get_crc("t3_r0", 0, 32'hAE42_6082, 4, 0);
            get_crc("t3_r1", 1, 32'hCBF4_3926, 1, 0);
         end
      join

      // Mid-chunk val stall plus consumer back-pressure in DONE.
      send_chunk(0, 3, tv[2].w, 2'd1, 1, 5, 1'b0);
      get_crc("t4_stall", 0, 32'hCBF4_3926, 1, 3);

      // rr pointer now at 1: simultaneous requests go to req1 first.
      fork
         send_chunk(0, 5, tv[1].w, 2'd1, -1, 0, 1'b1);
         send_chunk(1, 1, tv[0].w, 2'd0, -1, 0, 1'b0);
         begin
            get_crc("t7_r1", 1, 32'hAE42_6082, 4, 0);
            get_crc("t7_r0", 0, 32'h1F15_C489, 1, 0);
         end
      join

      for (int t = 0; t < 40; t++) begin
         id   = $urandom_range(0, NUM_REQ - 1);
         nw   = $urandom_range(1, 5);
         bcnt = 2'($urandom_range(0, 3));
         for (int k = 0; k < 5; k++) w[k] = $urandom;
         stall_after = (nw > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(0, nw - 2) : -1;
         stall_len   = $urandom_range(1, 4);
         hold        = $urandom_range(0, 3);
         send_chunk(id, nw, w, bcnt, stall_after, stall_len, 1'b0);
         get_crc($sformatf("rnd%0d", t), id, ref_crc(nw, w, bcnt), nbytes(bcnt), hold);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
